// File: rtl/register_file_if.sv
// register_file_if: write port and two read ports of the register file
interface register_file_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);
    logic             WE;
    logic [AW-1:0]    Waddr;
    logic [WIDTH-1:0] Wdata;
    logic             RE1;
    logic [AW-1:0]    Raddr1;
    logic [WIDTH-1:0] Dout1;
    logic             RE2;
    logic [AW-1:0]    Raddr2;
    logic [WIDTH-1:0] Dout2;
    modport master (
        output WE, Waddr, Wdata, RE1, Raddr1, RE2, Raddr2,
        input  Dout1, Dout2
    );
    modport slave (
        input  WE, Waddr, Wdata, RE1, Raddr1, RE2, Raddr2,
        output Dout1, Dout2
    );
endinterface

// File: rtl/register_file.sv
// register_file: one write port, two registered read ports with write-first bypass
module register_file #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 16,
    parameter int ZERO_R0 = 1
) (
    input logic             CLK,
    input logic             RSTn,
    register_file_if.slave  bus
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;

    // Effective write and next read values; zero register beats bypass, bypass beats storage
    always_comb begin
        wr_ok = bus.WE && !(ZERO_R0 != 0 && bus.Waddr == '0);
        rd1   = (ZERO_R0 != 0 && bus.Raddr1 == '0) ? '0 :
                (wr_ok && bus.Waddr == bus.Raddr1) ? bus.Wdata : mem[bus.Raddr1];
        rd2   = (ZERO_R0 != 0 && bus.Raddr2 == '0) ? '0 :
                (wr_ok && bus.Waddr == bus.Raddr2) ? bus.Wdata : mem[bus.Raddr2];
    end

    // Storage and read-data registers; enabled ports update, disabled ports hold
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            bus.Dout1 <= '0;
            bus.Dout2 <= '0;
        end else begin
            if (wr_ok) mem[bus.Waddr] <= bus.Wdata;
            if (bus.RE1) bus.Dout1 <= rd1;
            if (bus.RE2) bus.Dout2 <= rd2;
        end
    end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed vectors for 32x16 (zero and non-zero r0) and 8x4 builds
module tb_register_file;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    register_file_if #(.WIDTH(32), .DEPTH(16)) ifa ();
    register_file_if #(.WIDTH(32), .DEPTH(16)) ifb ();
    register_file_if #(.WIDTH(8),  .DEPTH(4))  ifc ();

    // The ZERO_R0=0 build sees exactly the same stimulus as the ZERO_R0=1 build
    assign ifb.WE     = ifa.WE;
    assign ifb.Waddr  = ifa.Waddr;
    assign ifb.Wdata  = ifa.Wdata;
    assign ifb.RE1    = ifa.RE1;
    assign ifb.Raddr1 = ifa.Raddr1;
    assign ifb.RE2    = ifa.RE2;
    assign ifb.Raddr2 = ifa.Raddr2;

    register_file #(.WIDTH(32), .DEPTH(16), .ZERO_R0(1)) dut_a (.CLK(clk), .RSTn(rst_n), .bus(ifa.slave));
    register_file #(.WIDTH(32), .DEPTH(16), .ZERO_R0(0)) dut_b (.CLK(clk), .RSTn(rst_n), .bus(ifb.slave));
    register_file #(.WIDTH(8),  .DEPTH(4),  .ZERO_R0(1)) dut_c (.CLK(clk), .RSTn(rst_n), .bus(ifc.slave));

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic        re1;
        logic [3:0]  ra1;
        logic        re2;
        logic [3:0]  ra2;
        logic [31:0] e1z;
        logic [31:0] e2z;
        logic [31:0] e1n;
        logic [31:0] e2n;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(logic we, logic [3:0] wa, logic [31:0] wd,
                                logic re1, logic [3:0] ra1, logic re2, logic [3:0] ra2,
                                logic [31:0] e1z, logic [31:0] e2z,
                                logic [31:0] e1n, logic [31:0] e2n);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd;
        v.re1 = re1; v.ra1 = ra1; v.re2 = re2; v.ra2 = ra2;
        v.e1z = e1z; v.e2z = e2z; v.e1n = e1n; v.e2n = e2n;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_a(logic we, logic [3:0] wa, logic [31:0] wd,
                           logic re1, logic [3:0] ra1, logic re2, logic [3:0] ra2);
        ifa.WE = we; ifa.Waddr = wa; ifa.Wdata = wd;
        ifa.RE1 = re1; ifa.Raddr1 = ra1; ifa.RE2 = re2; ifa.Raddr2 = ra2;
    endtask

    task automatic step_c(logic we, logic [1:0] wa, logic [7:0] wd,
                          logic re1, logic [1:0] ra1, logic re2, logic [1:0] ra2,
                          logic [7:0] e1, logic [7:0] e2, string name);
        ifc.WE = we; ifc.Waddr = wa; ifc.Wdata = wd;
        ifc.RE1 = re1; ifc.Raddr1 = ra1; ifc.RE2 = re2; ifc.Raddr2 = ra2;
        @(posedge clk); #1;
        chk({name, " c.dout1"}, {24'b0, ifc.Dout1}, {24'b0, e1});
        chk({name, " c.dout2"}, {24'b0, ifc.Dout2}, {24'b0, e2});
    endtask

    initial begin
        vecs[0]  = mk(1, 5,  32'h12345678, 0, 0,  0, 0,  32'h0,        32'h0,        32'h0,        32'h0);
        vecs[1]  = mk(0, 0,  32'h0,        1, 5,  1, 6,  32'h12345678, 32'h0,        32'h12345678, 32'h0);
        vecs[2]  = mk(1, 3,  32'hAAAA0000, 1, 3,  0, 0,  32'hAAAA0000, 32'h0,        32'hAAAA0000, 32'h0);
        vecs[3]  = mk(1, 3,  32'h0000BBBB, 1, 3,  1, 3,  32'h0000BBBB, 32'h0000BBBB, 32'h0000BBBB, 32'h0000BBBB);
        vecs[4]  = mk(1, 0,  32'hFFFFFFFF, 1, 0,  0, 0,  32'h0,        32'h0000BBBB, 32'hFFFFFFFF, 32'h0000BBBB);
        vecs[5]  = mk(0, 0,  32'h0,        1, 0,  1, 0,  32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF);
        vecs[6]  = mk(1, 7,  32'h77,       1, 7,  0, 0,  32'h77,       32'h0,        32'h77,       32'hFFFFFFFF);
        vecs[7]  = mk(1, 7,  32'h99,       0, 7,  1, 7,  32'h77,       32'h99,       32'h77,       32'h99);
        vecs[8]  = mk(0, 0,  32'h0,        0, 7,  0, 7,  32'h77,       32'h99,       32'h77,       32'h99);
        vecs[9]  = mk(0, 0,  32'h0,        0, 7,  1, 7,  32'h77,       32'h99,       32'h77,       32'h99);
        vecs[10] = mk(0, 0,  32'h0,        1, 7,  0, 0,  32'h99,       32'h99,       32'h99,       32'h99);
        vecs[11] = mk(0, 0,  32'h0,        1, 3,  1, 5,  32'h0000BBBB, 32'h12345678, 32'h0000BBBB, 32'h12345678);
        vecs[12] = mk(1, 15, 32'hDEADBEEF, 1, 14, 1, 15, 32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF);

        drive_a(0, 0, 0, 0, 0, 0, 0);
        ifc.WE = 0; ifc.Waddr = 0; ifc.Wdata = 0;
        ifc.RE1 = 0; ifc.Raddr1 = 0; ifc.RE2 = 0; ifc.Raddr2 = 0;
        #12 rst_n = 1'b1;
        chk("reset a.dout1", ifa.Dout1, 32'h0);
        chk("reset a.dout2", ifa.Dout2, 32'h0);
        chk("reset b.dout1", ifb.Dout1, 32'h0);
        chk("reset c.dout1", {24'b0, ifc.Dout1}, 32'h0);

        for (int i = 0; i < 13; i++) begin
            drive_a(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re1, vecs[i].ra1, vecs[i].re2, vecs[i].ra2);
            @(posedge clk); #1;
            chk($sformatf("vec%0d a.dout1", i), ifa.Dout1, vecs[i].e1z);
            chk($sformatf("vec%0d a.dout2", i), ifa.Dout2, vecs[i].e2z);
            chk($sformatf("vec%0d b.dout1", i), ifb.Dout1, vecs[i].e1n);
            chk($sformatf("vec%0d b.dout2", i), ifb.Dout2, vecs[i].e2n);
        end

        // Fill registers 1..15, then read two of them so the outputs are non-zero before reset
        for (int i = 1; i < 16; i++) begin
            drive_a(1, 4'(i), 32'hDEADBEEF, 0, 0, 0, 0);
            @(posedge clk); #1;
        end
        drive_a(0, 0, 0, 1, 1, 1, 9);
        @(posedge clk); #1;
        chk("pre-reset a.dout1", ifa.Dout1, 32'hDEADBEEF);
        chk("pre-reset a.dout2", ifa.Dout2, 32'hDEADBEEF);
        chk("pre-reset b.dout1", ifb.Dout1, 32'hDEADBEEF);

        // Mid-cycle reset: outputs clear without a clock edge; a write and reads during reset are ignored
        #3 rst_n = 1'b0;
        #1;
        chk("async reset a.dout1", ifa.Dout1, 32'h0);
        chk("async reset a.dout2", ifa.Dout2, 32'h0);
        chk("async reset b.dout2", ifb.Dout2, 32'h0);
        drive_a(1, 4, 32'h44444444, 1, 2, 1, 3);
        @(posedge clk); #1;
        chk("in-reset a.dout1", ifa.Dout1, 32'h0);
        chk("in-reset b.dout2", ifb.Dout2, 32'h0);
        drive_a(0, 0, 0, 0, 0, 0, 0);
        #3 rst_n = 1'b1;
        for (int i = 1; i < 16; i++) begin
            drive_a(0, 0, 0, 1, 4'(i), 1, 4'(i));
            @(posedge clk); #1;
            chk($sformatf("post-reset r%0d a.dout1", i), ifa.Dout1, 32'h0);
            chk($sformatf("post-reset r%0d b.dout2", i), ifb.Dout2, 32'h0);
        end
        drive_a(0, 0, 0, 0, 0, 0, 0);

        // Narrow build: hold, dual-port rewrite window, zero register
        step_c(1, 3, 8'h77, 1, 3, 0, 0, 8'h77, 8'h00, "c bypass");
        step_c(1, 3, 8'h99, 0, 3, 1, 3, 8'h77, 8'h99, "c rewrite");
        step_c(0, 0, 8'h00, 0, 3, 0, 3, 8'h77, 8'h99, "c hold1");
        step_c(0, 0, 8'h00, 0, 3, 0, 3, 8'h77, 8'h99, "c hold2");
        step_c(0, 0, 8'h00, 1, 3, 1, 3, 8'h99, 8'h99, "c reread");
        step_c(1, 0, 8'hFF, 1, 0, 1, 3, 8'h00, 8'h99, "c r0 write");
        step_c(0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 8'h00, "c r0 read");
        step_c(1, 1, 8'h5A, 1, 2, 1, 1, 8'h00, 8'h5A, "c r1 bypass");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
